// File: rtl/feature_frame_rx.sv
// feature_frame_rx: receives serial feature frames from the GPIO pads, assembles
// DATA_W-bit words and stores whole frames in a commit/rollback FIFO. A frame only
// becomes visible downstream once it has been received completely and closed cleanly.
module feature_frame_rx #(
  parameter int DATA_W   = 8,
  parameter int NUM_FEAT = 4,
  parameter int DEPTH    = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              pad_sclk,
  input  logic              pad_sdata,
  input  logic              pad_frame,
  output logic [DATA_W-1:0] feat_data,
  output logic              feat_last,
  output logic              feat_valid,
  input  logic              feat_ready,
  output logic              busy,
  output logic [7:0]        ovf_count,
  output logic [7:0]        frame_err_count,
  input  logic              clr_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int WW = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DONE  = 2'd2,
    ABORT = 2'd3
  } state_t;

  // Pad synchronizers; the third stage gives the previous value for edge detection
  logic sclk_s1_q, sclk_s2_q, sclk_s3_q;
  logic sdata_s1_q, sdata_s2_q;
  logic frame_s1_q, frame_s2_q, frame_s3_q;

  logic sclk_rise;
  logic frame_rise;
  logic frame_lvl;
  logic sdata_bit;

  state_t state_q, state_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]     word_cnt_q, word_cnt_d;
  logic [DATA_W-2:0] shreg_q, shreg_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]     start_ptr_q, start_ptr_d;
  logic [PW-1:0]     rd_ptr_q;

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [DATA_W:0]   head_word;
  logic [DATA_W-1:0] new_word;
  logic [DATA_W:0]   wr_word;
  logic              wr_en;
  logic              fifo_full;
  logic              last_word;
  logic              ovf_inc;
  logic              err_inc;
  logic [7:0]        ovf_cnt_q;
  logic [7:0]        err_cnt_q;

  // Bring the asynchronous pad signals into the wb_clk_i domain, all equally delayed
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      sclk_s1_q  <= 1'b0;
      sclk_s2_q  <= 1'b0;
      sclk_s3_q  <= 1'b0;
      sdata_s1_q <= 1'b0;
      sdata_s2_q <= 1'b0;
      frame_s1_q <= 1'b0;
      frame_s2_q <= 1'b0;
      frame_s3_q <= 1'b0;
    end else begin
      sclk_s1_q  <= pad_sclk;
      sclk_s2_q  <= sclk_s1_q;
      sclk_s3_q  <= sclk_s2_q;
      sdata_s1_q <= pad_sdata;
      sdata_s2_q <= sdata_s1_q;
      frame_s1_q <= pad_frame;
      frame_s2_q <= frame_s1_q;
      frame_s3_q <= frame_s2_q;
    end
  end

  assign sclk_rise  = sclk_s2_q & ~sclk_s3_q;
  assign frame_rise = frame_s2_q & ~frame_s3_q;
  assign frame_lvl  = frame_s2_q;
  assign sdata_bit  = sdata_s2_q;

  // Full counts uncommitted words too, so a frame in flight can never overrun unread data
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign new_word   = {shreg_q, sdata_bit};
  assign last_word  = (word_cnt_q == WW'(NUM_FEAT - 1));

  // Frame receive FSM: next state, shifting, FIFO writes, commit and rollback
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    shreg_d      = shreg_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    start_ptr_d  = start_ptr_q;
    wr_en        = 1'b0;
    wr_word      = '0;
    ovf_inc      = 1'b0;
    err_inc      = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_rise) begin
          bit_cnt_d   = '0;
          word_cnt_d  = '0;
          start_ptr_d = wr_ptr_q;
          state_d     = RECV;
        end
      end
      RECV: begin
        if (!frame_lvl) begin
          wr_ptr_d = start_ptr_q;
          err_inc  = 1'b1;
          state_d  = IDLE;
        end else if (sclk_rise) begin
          shreg_d = new_word[DATA_W-2:0];
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            if (fifo_full) begin
              wr_ptr_d = start_ptr_q;
              ovf_inc  = 1'b1;
              state_d  = ABORT;
            end else begin
              wr_en    = 1'b1;
              wr_word  = {last_word, new_word};
              wr_ptr_d = wr_ptr_q + PW'(1);
              if (last_word) begin
                state_d = DONE;
              end else begin
                word_cnt_d = word_cnt_q + WW'(1);
              end
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      DONE: begin
        if (!frame_lvl) begin
          commit_ptr_d = wr_ptr_q;
          state_d      = IDLE;
        end else if (sclk_rise) begin
          wr_ptr_d = start_ptr_q;
          err_inc  = 1'b1;
          state_d  = ABORT;
        end
      end
      ABORT: begin
        if (!frame_lvl) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM and write-side pointer registers
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      shreg_q      <= '0;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      start_ptr_q  <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      shreg_q      <= shreg_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      start_ptr_q  <= start_ptr_d;
    end
  end

  // FIFO storage; contents need no reset because the outputs are gated by feat_valid
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_ni && wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_word;
    end
  end

  // Read pointer advances on every accepted word
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      rd_ptr_q <= '0;
    end else if (feat_valid && feat_ready) begin
      rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign feat_valid = (commit_ptr_q != rd_ptr_q);
  assign head_word  = mem_q[rd_ptr_q[AW-1:0]];
  assign feat_data  = feat_valid ? head_word[DATA_W-1:0] : '0;
  assign feat_last  = feat_valid & head_word[DATA_W];
  assign busy       = (state_q != IDLE);

  // Saturating status counters; a clear beats a same-cycle increment
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni || clr_status) begin
      ovf_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      if (ovf_inc && (ovf_cnt_q != 8'hFF)) begin
        ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
      if (err_inc && (err_cnt_q != 8'hFF)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign ovf_count       = ovf_cnt_q;
  assign frame_err_count = err_cnt_q;

endmodule

// File: tb/tb_feature_frame_rx.sv
// tb_feature_frame_rx: directed and randomized frames against a queue-based model
// of which words must appear downstream and how the status counters move.
module tb_feature_frame_rx;

  localparam int DATA_W   = 8;
  localparam int NUM_FEAT = 4;
  localparam int DEPTH    = 8;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_ni = 1'b0;
  logic              pad_sclk = 1'b0;
  logic              pad_sdata = 1'b0;
  logic              pad_frame = 1'b0;
  logic [DATA_W-1:0] feat_data;
  logic              feat_last;
  logic              feat_valid;
  logic              feat_ready = 1'b0;
  logic              busy;
  logic [7:0]        ovf_count;
  logic [7:0]        frame_err_count;
  logic              clr_status = 1'b0;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  logic [8:0] expQ [$];
  int modelErr = 0;
  int modelOvf = 0;

  feature_frame_rx #(
    .DATA_W(DATA_W),
    .NUM_FEAT(NUM_FEAT),
    .DEPTH(DEPTH)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .pad_sclk(pad_sclk),
    .pad_sdata(pad_sdata),
    .pad_frame(pad_frame),
    .feat_data(feat_data),
    .feat_last(feat_last),
    .feat_valid(feat_valid),
    .feat_ready(feat_ready),
    .busy(busy),
    .ovf_count(ovf_count),
    .frame_err_count(frame_err_count),
    .clr_status(clr_status)
  );

  // 100 MHz system clock
  always #5 wb_clk_i = ~wb_clk_i;

  // Hard stop in case something hangs
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    assert (observed === expected) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  // Reference model: decides a frame's fate from its bit count and the free space
  task automatic modelFrame(input logic [31:0] bits, input int nBits, input bit extraEdge);
    int wordsDone;
    int room;
    wordsDone = nBits / DATA_W;
    room = DEPTH - expQ.size();
    if (wordsDone > room) begin
      if (modelOvf < 255) modelOvf = modelOvf + 1;
    end else if (nBits == DATA_W * NUM_FEAT && !extraEdge) begin
      for (int w = 0; w < NUM_FEAT; w++) begin
        logic [7:0] b;
        b = bits[31 - 8*w -: 8];
        expQ.push_back({(w == NUM_FEAT - 1), b});
      end
    end else begin
      if (modelErr < 255) modelErr = modelErr + 1;
    end
  endtask

  // Sends a frame MSB first; optionally an extra SCLK edge, latency check, or leave frame open
  task automatic applyStimulus(input logic [31:0] bits, input int nBits, input bit extraEdge,
                               input bit checkLatency, input bit endFrame);
    pad_frame = 1'b1;
    pad_sclk  = 1'b0;
    waitCycles(4);
    for (int i = 0; i < nBits; i++) begin
      pad_sdata = bits[31 - i];
      pad_sclk  = 1'b0;
      waitCycles(3);
      pad_sclk  = 1'b1;
      waitCycles(3);
    end
    if (extraEdge) begin
      pad_sdata = 1'($urandom_range(0, 1));
      pad_sclk  = 1'b0;
      waitCycles(3);
      pad_sclk  = 1'b1;
      waitCycles(3);
    end
    pad_sclk = 1'b0;
    if (endFrame) begin
      waitCycles(3);
      pad_frame = 1'b0;
      if (checkLatency) begin
        waitCycles(2);
        checkOutput("validBeforeCommit", feat_valid, 1'b0);
        waitCycles(1);
        checkOutput("validAfterCommit", feat_valid, 1'b1);
        waitCycles(3);
      end else begin
        waitCycles(6);
      end
      modelFrame(bits, nBits, extraEdge);
    end
  endtask

  // Drains nWords; mode 0 always ready, 1 toggling, 2 random
  task automatic drainWords(input int nWords, input int mode);
    int popped;
    int cyc;
    bit stalled;
    logic [8:0] held;
    logic [8:0] expWord;
    popped = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (popped < nWords && cyc < nWords * 40 + 50) begin
      @(negedge wb_clk_i);
      cyc = cyc + 1;
      if (stalled) begin
        checkOutput("stallValid", feat_valid, 1'b1);
        checkOutput("stallData", {feat_last, feat_data}, held);
      end
      if (mode == 0) feat_ready = 1'b1;
      else if (mode == 1) feat_ready = cyc[0];
      else feat_ready = 1'($urandom_range(0, 1));
      stalled = 1'b0;
      if (feat_valid) begin
        if (feat_ready) begin
          if (expQ.size() > 0) expWord = expQ.pop_front();
          else expWord = 9'h1FF;
          checkOutput("drainWord", {feat_last, feat_data}, expWord);
          popped = popped + 1;
        end else begin
          stalled = 1'b1;
          held = {feat_last, feat_data};
        end
      end
    end
    @(negedge wb_clk_i);
    feat_ready = 1'b0;
    checkOutput("drainCount", popped, nWords);
    checkOutput("emptyAfterDrain", feat_valid, 1'b0);
  endtask

  task automatic clearStatus();
    clr_status = 1'b1;
    waitCycles(1);
    clr_status = 1'b0;
    modelErr = 0;
    modelOvf = 0;
  endtask

  initial begin
    $display("[TB] start");
    waitCycles(3);
    wb_rst_ni = 1'b1;
    waitCycles(1);
    checkOutput("rstValid", feat_valid, 1'b0);
    checkOutput("rstLast", feat_last, 1'b0);
    checkOutput("rstData", feat_data, 8'h00);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstOvf", ovf_count, 8'd0);
    checkOutput("rstErr", frame_err_count, 8'd0);

    $display("[TB] single frame A5 3C FF 01");
    applyStimulus(32'hA53CFF01, 32, 1'b0, 1'b1, 1'b1);
    drainWords(expQ.size(), 0);
    checkOutput("t1Busy", busy, 1'b0);

    $display("[TB] frame dropped after two words");
    applyStimulus($urandom(), 16, 1'b0, 1'b0, 1'b1);
    checkOutput("t2Valid", feat_valid, 1'b0);
    checkOutput("t2Err", frame_err_count, 8'd1);
    checkOutput("t2ErrModel", frame_err_count, modelErr);
    checkOutput("t2Busy", busy, 1'b0);

    $display("[TB] overflow with feat_ready low");
    applyStimulus(32'h11121301, 32, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h21222301, 32, 1'b0, 1'b0, 1'b1);
    applyStimulus(32'h31323301, 32, 1'b0, 1'b0, 1'b1);
    checkOutput("t3Ovf", ovf_count, 8'd1);
    checkOutput("t3Stored", expQ.size(), 8);
    drainWords(8, 0);

    $display("[TB] extra SCLK edge after last word");
    clearStatus();
    applyStimulus($urandom(), 32, 1'b1, 1'b0, 1'b1);
    checkOutput("t4Err", frame_err_count, 8'd1);
    checkOutput("t4Valid", feat_valid, 1'b0);
    applyStimulus($urandom(), 32, 1'b0, 1'b0, 1'b1);
    drainWords(expQ.size(), 0);

    $display("[TB] toggling ready drain and clear collision");
    applyStimulus($urandom(), 32, 1'b0, 1'b0, 1'b1);
    applyStimulus($urandom(), 32, 1'b0, 1'b0, 1'b1);
    drainWords(expQ.size(), 1);
    applyStimulus($urandom(), 12, 1'b0, 1'b0, 1'b0);
    waitCycles(3);
    pad_frame = 1'b0;
    @(posedge wb_clk_i);
    @(posedge wb_clk_i);
    @(negedge wb_clk_i);
    clr_status = 1'b1;
    @(negedge wb_clk_i);
    clr_status = 1'b0;
    modelErr = 0;
    modelOvf = 0;
    checkOutput("clrBeatsInc", frame_err_count, 8'd0);
    checkOutput("clrOvf", ovf_count, 8'd0);
    waitCycles(2);
    checkOutput("clrBusy", busy, 1'b0);

    $display("[TB] randomized frames");
    for (int iter = 0; iter < 5; iter++) begin
      for (int f = 0; f < 3; f++) begin
        int kind;
        logic [31:0] bits;
        kind = int'($urandom_range(0, 3));
        bits = $urandom();
        if (kind <= 1) applyStimulus(bits, 32, 1'b0, 1'b0, 1'b1);
        else if (kind == 2) applyStimulus(bits, int'($urandom_range(1, 31)), 1'b0, 1'b0, 1'b1);
        else applyStimulus(bits, 32, 1'b1, 1'b0, 1'b1);
      end
      checkOutput("randErr", frame_err_count, modelErr);
      checkOutput("randOvf", ovf_count, modelOvf);
      drainWords(expQ.size(), 2);
    end

    $display("[TB] reset during third word");
    applyStimulus($urandom(), 32, 1'b0, 1'b0, 1'b1);
    checkOutput("preRstValid", feat_valid, 1'b1);
    applyStimulus($urandom(), 20, 1'b0, 1'b0, 1'b0);
    wb_rst_ni = 1'b0;
    pad_frame = 1'b0;
    pad_sclk  = 1'b0;
    waitCycles(1);
    wb_rst_ni = 1'b1;
    expQ.delete();
    modelErr = 0;
    modelOvf = 0;
    checkOutput("midRstValid", feat_valid, 1'b0);
    checkOutput("midRstLast", feat_last, 1'b0);
    checkOutput("midRstData", feat_data, 8'h00);
    checkOutput("midRstBusy", busy, 1'b0);
    checkOutput("midRstOvf", ovf_count, 8'd0);
    checkOutput("midRstErr", frame_err_count, 8'd0);
    waitCycles(6);
    applyStimulus($urandom(), 32, 1'b0, 1'b0, 1'b1);
    drainWords(expQ.size(), 0);
    checkOutput("postRstErr", frame_err_count, 8'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
